// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//   Serialises one 10-bit sample into a 16-bit MCP4911 write frame.
//   The frame is sent as SPI mode (0,0), MSB first, and is followed by an
//   LDAC_n pulse that updates the DAC output. The SCK timing comes from an
//   internal divider that runs on sysclk.
//
//   Parameters
//     CLK_DIV : sysclk cycles per SCK half-period H (1..255)
//     BUF     : VREF buffer bit, frame bit 14
//     GA_N    : gain bit, frame bit 13 (1 = 1x gain)
//
//   Ports
//     sysclk   in   system clock; all logic runs on posedge
//     reset    in   synchronous active-high reset
//     data_in  in   [9:0] unsigned sample, valid together with load
//     load     in   one-cycle strobe that starts a frame when idle
//     busy     out  high while a frame is in progress (35*H cycles)
//     done     out  one-cycle pulse after the frame completes
//     overrun  out  sticky flag: a load arrived while busy
//     dac_cs_n out  SPI chip select, active low
//     dac_sck  out  SPI clock, idles low
//     dac_sdi  out  SPI data to the DAC
//     dac_ld_n out  LDAC, active low
// -----------------------------------------------------------------------------
module dac_spi_tx #(
  parameter int CLK_DIV = 25,
  parameter bit BUF     = 1'b0,
  parameter bit GA_N    = 1'b1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_TAIL  = 3'd2,
    ST_CSHI  = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        ld_n_q, ld_n_d;
  logic        tick_s;

  // Write command: 0, BUF, GA_N, SHDN_n=1, ten data bits, two don't-care zeros.
  function automatic logic [15:0] build_frame(input logic [9:0] d);
    return {1'b0, BUF, GA_N, 1'b1, d, 2'b00};
  endfunction

  // Divider tick marks the last sysclk cycle of an SCK half-period.
  assign tick_s = (div_q == DIV_LAST);

  // Next-state and output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (load & busy_q);
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    ld_n_d    = ld_n_q;

    // The divider only runs while a frame is active, so each frame starts
    // with a full-length low SCK phase.
    if (state_q == ST_IDLE) begin
      div_d = 8'd0;
    end else if (tick_s) begin
      div_d = 8'd0;
    end else begin
      div_d = div_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d = build_frame(data_in);
          sdi_d   = data_in[9] & 1'b0 | 1'b0; // bit 15 of the frame is always 0
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          bit_d   = 4'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!tick_s) begin
          state_d = ST_SHIFT;
        end else if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          // Falling edge: advance to the next bit, so data is stable
          // for the whole high phase around the next rising edge.
          sck_d = 1'b0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = ST_TAIL;
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            sdi_d   = shift_q[14];
          end
        end
      end
      ST_TAIL: begin
        if (tick_s) begin
          cs_n_d  = 1'b1;
          state_d = ST_CSHI;
        end else begin
          state_d = ST_TAIL;
        end
      end
      ST_CSHI: begin
        if (tick_s) begin
          ld_n_d  = 1'b0;
          state_d = ST_LDAC;
        end else begin
          state_d = ST_CSHI;
        end
      end
      ST_LDAC: begin
        if (tick_s) begin
          ld_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sdi_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LDAC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        sdi_d   = 1'b0;
        ld_n_d  = 1'b1;
        bit_d   = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 4'd0;
      shift_q   <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      ld_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      ld_n_q    <= ld_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = sdi_q;
  assign dac_ld_n = ld_n_q;

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Serialiser between the echo processor's 10-bit data_out and the off-chip MCP4911 10-bit SPI DAC. On a one-cycle load strobe it captures one sample, then shifts one 16-bit write frame (SPI mode 0,0, MSB first) and pulses LDAC_n to update the analogue output. It is driven by the same sysclk as the processor and keeps its own SCK divider.

Parameters:
CLK_DIV, 25, sysclk cycles per SCK half-period (H); legal 1..255; 25 gives 1 MHz SCK from 50 MHz.
BUF, 0, VREF buffer bit (frame bit 14).
GA_N, 1, gain bit (frame bit 13); 1 selects 1x gain.

Ports:
sysclk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous active-high reset.
data_in  in  10  sample to convert, unsigned offset-binary (already includes DAC_OFFSET).
load  in  1  one-cycle strobe; data_in is valid in the same cycle.
busy  out  1  high while a frame is in progress.
done  out  1  one-cycle pulse at end of frame.
overrun  out  1  sticky; a load arrived while busy. Cleared only by reset.
dac_cs_n  out  1  SPI chip select, active low.
dac_sck  out  1  SPI clock, idles low.
dac_sdi  out  1  SPI data to DAC.
dac_ld_n  out  1  LDAC, active low.

Behaviour:
- Reset (posedge with reset=1): state=IDLE, busy=0, done=0, overrun=0, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1, divider and bit counters=0. Reset overrides load in the same cycle. Reset mid-frame aborts at once with the same values; no LDAC pulse is issued.
- Frame word, registered at accept: {1'b0, BUF, GA_N, 1'b1 (SHDN_n), data_in[9:0], 2'b00}. Example: data_in=10'h2A5 with defaults gives 16'h3A94.
- Accept: load=1 and busy=0 at edge N. Capture the frame; busy=1, dac_cs_n=0, dac_sdi=bit15 all from cycle N+1.
- Divider: a counter issues a tick every H sysclk cycles. All phase changes below occur only on ticks.
- SHIFT state: 16 bits, MSB first. For each bit, SCK stays low for H cycles, then high for H cycles. dac_sdi changes only when SCK goes low, so it is stable around every rising edge. 16 rising edges in total; the bit counter wraps 15 to 0 to mark the end.
- TAIL state: SCK low and cs_n low for H cycles.
- CSHI state: cs_n=1 for H cycles.
- LDAC state: dac_ld_n=0 for H cycles.
- Then IDLE: in one cycle, dac_ld_n=1, busy=0, done=1 and dac_sdi=0. done lasts exactly 1 cycle.
- Frame length: busy is high for exactly 35*H cycles (32H shift + 3H).
- A load in the done cycle sees busy=0 and is accepted, so back-to-back frames have no gap cycle.
- A load while busy=1 is dropped and sets overrun=1 on the next cycle. The frame in flight is unaffected. data_in changes during a frame are ignored.
- dac_sck and dac_cs_n are never low-to-high or high-to-low in the same cycle except as stated. SCK is low whenever cs_n toggles.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. CLK_DIV=2; load with data_in=10'h2A5 -> bits sampled on 16 SCK rising edges = 16'h3A94. busy high for 70 cycles. One dac_ld_n low pulse of 2 cycles after cs_n rises. done is one cycle.
2. data_in=10'h000, then 10'h3FF issued in the done cycle of the first frame -> frames 16'h3000 and 16'h3FFC. The second frame's cs_n falls on the cycle after done with no idle gap.
3. Load during SHIFT (cycle 20 of a frame) -> overrun=1 from next cycle and stays 1. The current frame still shifts its original data. No second frame follows.
4. reset asserted at cycle 30 of a frame -> next cycle cs_n=1, sck=0, busy=0, ld_n=1, overrun=0. No LDAC pulse. A fresh load then produces a correct full frame.
5. CLK_DIV=1 with BUF=1, GA_N=0; load 10'h155 -> frame 16'h5554, SCK period 2 cycles, busy 35 cycles.
6. reset and load in the same cycle -> load ignored; busy stays 0.
